run_length_detector: RTL
========================

// Module: run_length_detector
// PURPOSE
//  Parametrised ASM sequence detector on serial input x: tracks consecutive 1s through
//  RUN_LEN Moore states (one-hot state_oh); final state gives Mealy-style z_cont / z_end.
//  Adds: generic run length, input qualifier en, optional registered Z outputs,
//  saturating run counter, captured length of last completed run. Used as protocol monitor.
// PARAMETERS
//  RUN_LEN  3  number of states S0..S(RUN_LEN-1); final state reached after RUN_LEN-1 ones; >=2
//  CNT_W    4  width of run_cnt/last_run; require 2**CNT_W-1 >= RUN_LEN-1
//  REG_Z    0  0 = z_* combinational (Mealy, same cycle); 1 = z_* registered (+1 cycle)
// PORTS
//  clk       in   1        rising-edge clock
//  reset     in   1        synchronous, active-low (0 = reset at next posedge clk)
//  en        in   1        qualifies x; en=0 -> x ignored, all state held
//  x         in   1        serial data bit
//  state_oh  out  RUN_LEN  Moore one-hot: bit k = 1 while in Sk
//  z_cont    out  1        run continues in final state (en & x & in S(RUN_LEN-1))
//  z_end     out  1        run ends from final state (en & !x & in S(RUN_LEN-1))
//  run_cnt   out  CNT_W    accepted consecutive 1s so far, saturating
//  last_run  out  CNT_W    run_cnt value when last z_end condition occurred
// BEHAVIOUR
//  Reset (reset=0 at posedge): ps=S0, state_oh=...001, run_cnt=0, last_run=0, registered z_*=0;
//   reset wins over en/x; mid-run reset discards the run (last_run NOT updated).
//  Transitions (evaluated only when en=1; en=0 -> ps holds):
//   Sk, k<RUN_LEN-1: x=1 -> S(k+1); x=0 -> S0.
//   S(RUN_LEN-1):    x=1 -> stay;   x=0 -> S0.
//  state_oh: registered-state decode only, never depends on x/en; exactly one bit set always.
//  z outputs, REG_Z=0: pure combinational from ps,en,x; valid same cycle; both 0 outside final
//   state or when en=0; never both 1.
//  z outputs, REG_Z=1: same terms flopped; appear on cycle after the qualifying sample; 0 in reset.
//  run_cnt: en&x -> run_cnt+1, saturating at 2**CNT_W-1 (no wrap); en&!x -> 0; en=0 -> hold.
//   Invariant: in Sk with k<RUN_LEN-1, run_cnt==k; in final state run_cnt>=RUN_LEN-1.
//  last_run: loaded with current run_cnt on the same edge where z_end condition (en & !x & final)
//   is true; otherwise holds. Runs ending before the final state do not update it.
//  Latency: ps/run_cnt/last_run update 1 edge after sampled en,x. All regs on posedge clk only.
// TESTING  (RUN_LEN=3, CNT_W=4 unless noted)
//  1. Reset: hold reset=0 2 cycles, x=1,en=1 -> state_oh=001, run_cnt=0, last_run=0, z_*=0.
//  2. REG_Z=0, en=1, x=1,1,1,0 -> state_oh 001,010,100,100 (then 001); z_cont=1 on 3rd x=1 cycle
//     only; z_end=1 on x=0 cycle; after that edge last_run=3, run_cnt=0.
//  3. Short run: x=1,0 -> S0->S1->S0, z_*=0 throughout, last_run unchanged (0).
//  4. en gating: reach S2, drive en=0 with x toggling 4 cycles -> state_oh=100, run_cnt=2,
//     z_*=0; then en=1,x=0 -> z_end=1.
//  5. Saturation, CNT_W=2: 6 accepted 1s -> run_cnt 1,2,3,3,3,3; x=0 -> last_run=3.
//  6. REG_Z=1: repeat test 2 -> z_cont/z_end each exactly 1 cycle later than REG_Z=0 case;
//     reset=0 asserted in S2 with x=1 -> next cycle S0, run_cnt=0, z_*=0, last_run unchanged.

Source files
------------

// File: rtl/run_length_detector.sv
// Serial run-of-ones detector: one-hot Moore state chain with Mealy z_cont/z_end in the
// final state, a saturating run counter and a capture of the length of the last finished run.
module run_length_detector #(
    parameter int RUN_LEN = 32'd3,
    parameter int CNT_W   = 32'd4,
    parameter bit REG_Z   = 1'b0
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               en,
    input  logic               x,
    output logic [RUN_LEN-1:0] state_oh,
    output logic               z_cont,
    output logic               z_end,
    output logic [CNT_W-1:0]   run_cnt,
    output logic [CNT_W-1:0]   last_run
);

    localparam logic [RUN_LEN-1:0] S0       = {{(RUN_LEN-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0]   CNT_ZERO = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0]   CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0]   CNT_MAX  = {CNT_W{1'b1}};

    logic [RUN_LEN-1:0] ps_r;
    logic [RUN_LEN-1:0] ps_nxt_s;
    logic               final_s;
    logic [CNT_W-1:0]   run_cnt_r;
    logic [CNT_W-1:0]   run_cnt_nxt_s;
    logic [CNT_W-1:0]   last_run_r;
    logic               z_cont_s;
    logic               z_end_s;

    function automatic logic is_onehot(input logic [RUN_LEN-1:0] v);
        int unsigned ones;
        ones = 32'd0;
        for (int i = 0; i < RUN_LEN; i++) begin
            ones = ones + {31'd0, v[i]};
        end
        return (ones == 32'd1);
    endfunction

    assign final_s  = ps_r[RUN_LEN-1];
    assign z_cont_s = en & x & final_s;
    assign z_end_s  = en & ~x & final_s;

    // Next state: advance along the chain on accepted ones; a corrupted encoding falls back to S0.
    always_comb begin
        ps_nxt_s = ps_r;
        if (!is_onehot(ps_r)) begin
            ps_nxt_s = S0;
        end else if (en) begin
            if (!x) begin
                ps_nxt_s = S0;
            end else if (final_s) begin
                ps_nxt_s = ps_r;
            end else begin
                ps_nxt_s = {ps_r[RUN_LEN-2:0], 1'b0};
            end
        end else begin
            ps_nxt_s = ps_r;
        end
    end

    // Run counter next value: saturate instead of wrapping so long runs stay visibly long.
    always_comb begin
        run_cnt_nxt_s = run_cnt_r;
        if (en) begin
            if (!x) begin
                run_cnt_nxt_s = CNT_ZERO;
            end else if (run_cnt_r == CNT_MAX) begin
                run_cnt_nxt_s = run_cnt_r;
            end else begin
                run_cnt_nxt_s = run_cnt_r + CNT_ONE;
            end
        end else begin
            run_cnt_nxt_s = run_cnt_r;
        end
    end

    // State, counter and last-run capture registers.
    always_ff @(posedge clk) begin
        if (!reset) begin
            ps_r       <= S0;
            run_cnt_r  <= CNT_ZERO;
            last_run_r <= CNT_ZERO;
        end else begin
            ps_r      <= ps_nxt_s;
            run_cnt_r <= run_cnt_nxt_s;
            if (z_end_s) begin
                last_run_r <= run_cnt_r;
            end else begin
                last_run_r <= last_run_r;
            end
        end
    end

    generate
        if (REG_Z) begin : g_reg_z
            logic z_cont_r;
            logic z_end_r;

            // Registered Z outputs, one cycle behind the qualifying sample.
            always_ff @(posedge clk) begin
                if (!reset) begin
                    z_cont_r <= 1'b0;
                    z_end_r  <= 1'b0;
                end else begin
                    z_cont_r <= z_cont_s;
                    z_end_r  <= z_end_s;
                end
            end

            assign z_cont = z_cont_r;
            assign z_end  = z_end_r;
        end else begin : g_comb_z
            assign z_cont = z_cont_s;
            assign z_end  = z_end_s;
        end
    endgenerate

    assign state_oh = ps_r;
    assign run_cnt  = run_cnt_r;
    assign last_run = last_run_r;

endmodule
